// File: rtl/packet_output_arbiter.sv
// Round-robin, packet-locked output arbiter: grants one input FIFO for a whole
// packet and streams its flits through a single registered valid/ready stage.
module packet_output_arbiter #(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS-1:0]            fifo_empty,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] fifo_dout,
  input  logic [N_INPUTS-1:0]            route_req,
  output logic [N_INPUTS-1:0]            fifo_rd_en,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  input  logic                           out_ready,
  output logic [N_INPUTS-1:0]            grant,
  output logic                           busy
);

  localparam int PTR_W = $clog2(N_INPUTS);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [N_INPUTS-1:0]     grant_q, grant_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  logic [N_INPUTS-1:0]     cand;
  logic                    win_found;
  logic [PTR_W-1:0]        win_idx;
  logic [DATA_WIDTH-1:0]   owner_flit;
  logic                    owner_empty;
  logic                    load;

  // Type field: bit 0 marks a packet start (head/single), bit 1 a packet end (tail/single).
  function automatic logic flit_starts(input logic [DATA_WIDTH-1:0] f);
    return f[DATA_WIDTH-2];
  endfunction

  function automatic logic flit_ends(input logic [DATA_WIDTH-1:0] f);
    return f[DATA_WIDTH-1];
  endfunction

  always_comb begin
    cand = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      cand[i] = ~fifo_empty[i] & route_req[i] &
                flit_starts(fifo_dout[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Two passes give the circular search starting at rr_ptr without a modulo.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (!win_found && cand[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < N_INPUTS; i++) begin
      if (!win_found && cand[i] && (PTR_W'(i) < rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    owner_flit  = '0;
    owner_empty = 1'b1;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (owner_q == PTR_W'(i)) begin
        owner_flit  = fifo_dout[i*DATA_WIDTH +: DATA_WIDTH];
        owner_empty = fifo_empty[i];
      end
    end
  end

  assign load = (state_q == LOCKED) & ~owner_empty & (~out_valid_q | out_ready);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          owner_d = win_idx;
          grant_d = {{(N_INPUTS-1){1'b0}}, 1'b1} << win_idx;
        end
      end
      LOCKED: begin
        if (load && flit_ends(owner_flit)) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_q == PTR_W'(N_INPUTS-1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The output register drains in either state.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = owner_flit;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // grant_q is one-hot on the owner whenever LOCKED, so it doubles as the pop mask.
  assign fifo_rd_en = load ? grant_q : '0;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign grant      = grant_q;
  assign busy       = (state_q == LOCKED);

endmodule

// File: tb/tb_packet_output_arbiter.sv
// Bench for packet_output_arbiter: queue-based FIFO models, a behavioural
// reference of the arbitration rules, directed scenarios and a random phase.
module tb_packet_output_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   fifo_empty;
  logic [N*W-1:0] fifo_dout;
  logic [N-1:0]   route_req;
  logic [N-1:0]   fifo_rd_en;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           busy;

  packet_output_arbiter #(.N_INPUTS(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .route_req(route_req), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fq[N][$];
  logic [W-1:0] delivered[$];
  logic [N-1:0] grant_log[$];
  logic [N-1:0] prev_grant, grant_or, rd_or;
  int           rd_pulses;
  int           n_cmp = 0;
  int           n_err = 0;

  // Reference state: arbitration lock, owner, round-robin pointer, output register.
  bit           m_locked;
  int           m_owner, m_ptr;
  bit           m_ov;
  logic [W-1:0] m_od;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_start(input logic [W-1:0] f);
    return (f[31:30] == 2'b01) || (f[31:30] == 2'b11);
  endfunction

  function automatic bit is_end(input logic [W-1:0] f);
    return (f[31:30] == 2'b10) || (f[31:30] == 2'b11);
  endfunction

  function automatic logic [W-1:0] dget(input int k);
    return (k < delivered.size()) ? delivered[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [N-1:0] gget(input int k);
    return (k < grant_log.size()) ? grant_log[k] : 4'hF;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]        = (fq[i].size() == 0);
      fifo_dout[i*W +: W]  = (fq[i].size() != 0) ? fq[i][0] : 32'h0;
    end
  endtask

  task automatic push_pkt(input int i, input int len, input logic [29:0] tag);
    if (len == 1) fq[i].push_back({2'b11, tag});
    else begin
      fq[i].push_back({2'b01, tag});
      for (int b = 1; b < len - 1; b++) fq[i].push_back({2'b00, tag + 30'(b)});
      fq[i].push_back({2'b10, tag + 30'(len - 1)});
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_ov = 0; m_od = '0;
    prev_grant = '0;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic cycle();
    int pop, idx;
    bit load, nl, nov;
    int no, np;
    logic [W-1:0] nod;
    logic [N-1:0] exp_rd, exp_g;
    drive();
    #1;
    exp_g = m_locked ? (4'b0001 << m_owner) : 4'b0000;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("grant", grant, exp_g);
    chk("busy", busy, m_locked);
    if (out_valid && out_ready) delivered.push_back(out_data);
    if (grant != 0 && prev_grant == 0) grant_log.push_back(grant);
    prev_grant = grant;
    grant_or |= grant;
    rd_or |= fifo_rd_en;
    if (fifo_rd_en != 0) rd_pulses++;

    pop = -1; load = 0; exp_rd = '0;
    nl = m_locked; no = m_owner; np = m_ptr; nov = m_ov; nod = m_od;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!nl && fq[idx].size() > 0 && route_req[idx] && is_start(fq[idx][0])) begin
          nl = 1; no = idx;
        end
      end
    end else if (fq[m_owner].size() > 0 && (!m_ov || out_ready)) begin
      load = 1; exp_rd[m_owner] = 1'b1; pop = m_owner;
      nov = 1; nod = fq[m_owner][0];
      if (is_end(nod)) begin nl = 0; np = (m_owner + 1) % N; end
    end
    if (!load && out_ready) nov = 0;
    chk("fifo_rd_en", fifo_rd_en, exp_rd);
    m_locked = nl; m_owner = no; m_ptr = np; m_ov = nov; m_od = nod;
    @(posedge clk);
    #1;
    if (pop >= 0) void'(fq[pop].pop_front());
    drive();
  endtask

  // Asserts rst between edges, checks the immediate effect, releases after one edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp3[6];
    rst = 1'b1; route_req = '0; out_ready = 1'b0;
    grant_or = '0; rd_or = '0; rd_pulses = 0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    rst = 1'b0;

    // Single packet: inputs 1 and 3 each hold a 3-flit packet.
    fq[1].push_back(32'h4000_0001); fq[1].push_back(32'h0000_0011); fq[1].push_back(32'h8000_00FF);
    fq[3].push_back(32'h4000_0003); fq[3].push_back(32'h0000_0033); fq[3].push_back(32'h8000_00F3);
    route_req = 4'b1010; out_ready = 1'b1;
    delivered.delete(); grant_log.delete();
    cycle();
    cycle();
    chk("t1_grant_in1", grant, 4'b0010);
    repeat (8) cycle();
    chk("t1_first_grant", gget(0), 4'b0010);
    chk("t1_second_grant", gget(1), 4'b1000);
    chk("t1_count", delivered.size(), 6);
    chk("t1_head", dget(0), 32'h4000_0001);
    chk("t1_tail", dget(2), 32'h8000_00FF);
    chk("t1_next_head", dget(3), 32'h4000_0003);

    // Round-robin fairness with single-flit packets everywhere.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++) push_pkt(i, 1, 30'(i * 16 + j));
    route_req = 4'b1111; out_ready = 1'b1;
    grant_log.delete(); rd_pulses = 0;
    repeat (26) cycle();
    for (int k = 0; k < 8; k++) chk("t2_rr_order", gget(k), 4'b0001 << (k % 4));
    chk("t2_pulses", rd_pulses, 12);
    chk("t2_grants", grant_log.size(), 12);

    // Backpressure for 5 cycles mid-packet.
    do_reset();
    push_pkt(0, 6, 30'h100);
    exp3[0] = 32'h4000_0100; exp3[1] = 32'h0000_0101; exp3[2] = 32'h0000_0102;
    exp3[3] = 32'h0000_0103; exp3[4] = 32'h0000_0104; exp3[5] = 32'h8000_0105;
    route_req = 4'b0001; out_ready = 1'b1;
    delivered.delete();
    repeat (4) cycle();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      chk("t3_hold_data", out_data, 32'h0000_0102);
      chk("t3_hold_rd", fifo_rd_en, 0);
    end
    out_ready = 1'b1;
    repeat (8) cycle();
    chk("t3_count", delivered.size(), 6);
    for (int k = 0; k < 6; k++) chk("t3_order", dget(k), exp3[k]);

    // Starved owner blocks input 2 until its tail arrives.
    do_reset();
    fq[0].push_back(32'h4000_0200);
    fq[2].push_back(32'h4000_0300); fq[2].push_back(32'h8000_0301);
    route_req = 4'b0101; out_ready = 1'b1;
    delivered.delete(); grant_log.delete();
    repeat (6) cycle();
    chk("t4_locked_grant", grant, 4'b0001);
    chk("t4_busy", busy, 1);
    chk("t4_in2_untouched", fq[2].size(), 2);
    fq[0].push_back(32'h8000_0201);
    repeat (8) cycle();
    chk("t4_grant_seq0", gget(0), 4'b0001);
    chk("t4_grant_seq1", gget(1), 4'b0100);
    chk("t4_flit0", dget(1), 32'h8000_0201);
    chk("t4_flit2", dget(2), 32'h4000_0300);

    // Body flit at the front of input 0 while idle.
    do_reset();
    fq[0].push_back(32'h0000_0400);
    fq[1].push_back(32'h4000_0500); fq[1].push_back(32'h8000_0501);
    route_req = 4'b0011; out_ready = 1'b1;
    delivered.delete(); grant_log.delete(); grant_or = '0; rd_or = '0;
    repeat (8) cycle();
    chk("t5_no_grant0", grant_or[0], 0);
    chk("t5_no_pop0", rd_or[0], 0);
    chk("t5_in0_kept", fq[0].size(), 1);
    chk("t5_grant1", gget(0), 4'b0010);
    chk("t5_delivered", delivered.size(), 2);
    fq[0].delete();

    // Reset in the middle of a 4-flit packet from input 2 (rr_ptr was 2).
    do_reset();
    push_pkt(1, 1, 30'h600);
    push_pkt(2, 4, 30'h700);
    route_req = 4'b0110; out_ready = 1'b1;
    for (int c = 0; c < 20 && fq[2].size() != 2; c++) cycle();
    chk("t6_two_popped", fq[2].size(), 2);
    chk("t6_pre_busy", busy, 1);
    do_reset();
    chk("t6_remaining", fq[2].size(), 2);
    fq[2].delete();
    push_pkt(1, 1, 30'h601);
    push_pkt(3, 1, 30'h801);
    route_req = 4'b1010;
    grant_log.delete();
    repeat (4) cycle();
    chk("t6_ptr_zero", gget(0), 4'b0010);

    // Random traffic, routing and backpressure.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (fq[i].size() < 6 && $urandom_range(0, 3) == 0)
          push_pkt(i, int'($urandom_range(1, 4)), 30'($urandom));
      route_req = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
